// File: rtl/operand_entry_seq.sv
// Sequenced operand entry (CONTR -> SRC_1 -> SRC_2 -> READY) driven by touch input and debounced NEXT/CLEAR.
// Field outputs register one cycle after input_valid; button action lands DEBOUNCE_CYCLES+3 cycles after the press.

module operand_entry_debounce #(
    parameter int CYCLES = 10000
) (
    input  logic clk,
    input  logic resetn,
    input  logic raw,
    output logic pulse
);
    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic          armed;
    logic [CW-1:0] cnt;

    // Synchronizer resets to "pressed" so a button held through reset release is
    // never armed until it has actually been seen low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b0;
            armed <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (!sync2) begin
                armed <= 1'b1;
            end
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= sync2;
                cnt   <= '0;
                pulse <= sync2 & armed;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

module operand_entry_seq #(
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        input_valid,
    input  logic [31:0] input_value,
    input  logic        btn_next_raw,
    input  logic        btn_clear_raw,
    output logic [3:0]  alu_control,
    output logic [31:0] alu_src1,
    output logic [31:0] alu_src2,
    output logic [1:0]  cur_field,
    output logic        operands_ready,
    output logic        ready_pulse,
    output logic        ctrl_trunc_err
);
    typedef enum logic [1:0] {
        S_CTRL  = 2'd0,
        S_SRC1  = 2'd1,
        S_SRC2  = 2'd2,
        S_READY = 2'd3
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [3:0]  ctrl_n;
    logic [31:0] src1_n;
    logic [31:0] src2_n;
    logic        err_n;
    logic        next_p;
    logic        clear_p;

    operand_entry_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_next_db (
        .clk    (clk),
        .resetn (resetn),
        .raw    (btn_next_raw),
        .pulse  (next_p)
    );

    operand_entry_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk    (clk),
        .resetn (resetn),
        .raw    (btn_clear_raw),
        .pulse  (clear_p)
    );

    // Clear beats capture beats advance; a capture coincident with NEXT lands in the old field.
    always_comb begin
        state_n = state;
        ctrl_n  = alu_control;
        src1_n  = alu_src1;
        src2_n  = alu_src2;
        err_n   = ctrl_trunc_err;
        if (clear_p) begin
            state_n = S_CTRL;
            ctrl_n  = 4'd0;
            src1_n  = 32'd0;
            src2_n  = 32'd0;
            err_n   = 1'b0;
        end else begin
            if (input_valid) begin
                unique case (state)
                    S_CTRL: begin
                        ctrl_n = input_value[3:0];
                        err_n  = |input_value[31:4];
                    end
                    S_SRC1:  src1_n = input_value;
                    S_SRC2:  src2_n = input_value;
                    S_READY: ;
                endcase
            end
            if (next_p) begin
                unique case (state)
                    S_CTRL:  state_n = S_SRC1;
                    S_SRC1:  state_n = S_SRC2;
                    S_SRC2:  state_n = S_READY;
                    S_READY: state_n = S_CTRL;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= S_CTRL;
            alu_control    <= 4'd0;
            alu_src1       <= 32'd0;
            alu_src2       <= 32'd0;
            ctrl_trunc_err <= 1'b0;
            operands_ready <= 1'b0;
            ready_pulse    <= 1'b0;
        end else begin
            state          <= state_n;
            alu_control    <= ctrl_n;
            alu_src1       <= src1_n;
            alu_src2       <= src2_n;
            ctrl_trunc_err <= err_n;
            operands_ready <= (state_n == S_READY);
            ready_pulse    <= (state_n == S_READY) && (state != S_READY);
        end
    end

    assign cur_field = state;
endmodule

// File: tb/tb_operand_entry_seq.sv
// Directed bench for operand_entry_seq: per-cycle comparison against a behavioural model plus literal checkpoints.
module tb_operand_entry_seq;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        input_valid = 1'b0;
    logic [31:0] input_value = 32'd0;
    logic        btn_next_raw = 1'b0;
    logic        btn_clear_raw = 1'b0;
    logic [3:0]  alu_control;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [1:0]  cur_field;
    logic        operands_ready;
    logic        ready_pulse;
    logic        ctrl_trunc_err;

    int errors = 0;
    int checks = 0;
    int rp_count = 0;

    operand_entry_seq #(.DEBOUNCE_CYCLES(D)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .input_valid    (input_valid),
        .input_value    (input_value),
        .btn_next_raw   (btn_next_raw),
        .btn_clear_raw  (btn_clear_raw),
        .alu_control    (alu_control),
        .alu_src1       (alu_src1),
        .alu_src2       (alu_src2),
        .cur_field      (cur_field),
        .operands_ready (operands_ready),
        .ready_pulse    (ready_pulse),
        .ctrl_trunc_err (ctrl_trunc_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a button level is accepted once the (two-cycle delayed) raw sample has
    // differed from the accepted level for D samples in a row; a press is only honoured
    // once the button has been seen released since reset.
    bit          h0 [2];
    bit          h1 [2];
    bit          acc [2];
    bit          armed [2];
    bit          pend [2];
    int          run [2];
    logic [1:0]  m_field;
    logic [3:0]  m_ctrl;
    logic [31:0] m_s1;
    logic [31:0] m_s2;
    logic        m_err;
    logic        m_rdy;
    logic        m_rp;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int b = 0; b < 2; b++) begin
                h0[b] = 1'b1; h1[b] = 1'b1; acc[b] = 1'b0;
                armed[b] = 1'b0; pend[b] = 1'b0; run[b] = 0;
            end
            m_field = 2'd0; m_ctrl = 4'd0; m_s1 = 32'd0; m_s2 = 32'd0;
            m_err = 1'b0; m_rdy = 1'b0; m_rp = 1'b0;
        end else begin
            bit np, cp, d;
            bit rawv [2];
            logic [1:0] old_field;
            np = pend[0];
            cp = pend[1];
            rawv[0] = btn_next_raw;
            rawv[1] = btn_clear_raw;
            for (int b = 0; b < 2; b++) begin
                d = h1[b]; h1[b] = h0[b]; h0[b] = rawv[b];
                pend[b] = 1'b0;
                if (d == acc[b]) run[b] = 0;
                else begin
                    run[b]++;
                    if (run[b] == D) begin
                        acc[b] = d;
                        run[b] = 0;
                        pend[b] = d && armed[b];
                    end
                end
                if (!d) armed[b] = 1'b1;
            end
            old_field = m_field;
            if (cp) begin
                m_field = 2'd0; m_ctrl = 4'd0; m_s1 = 32'd0; m_s2 = 32'd0; m_err = 1'b0;
            end else begin
                if (input_valid) begin
                    if (m_field == 2'd0) begin
                        m_ctrl = input_value[3:0];
                        m_err  = (input_value >> 4) != 32'd0;
                    end else if (m_field == 2'd1) m_s1 = input_value;
                    else if (m_field == 2'd2) m_s2 = input_value;
                end
                if (np) m_field = m_field + 2'd1;
            end
            m_rdy = (m_field == 2'd3);
            m_rp  = (m_field == 2'd3) && (old_field != 2'd3);
        end
    end

    always @(negedge clk) begin
        if (resetn) begin
            check("cmp_control", {28'd0, alu_control}, {28'd0, m_ctrl});
            check("cmp_src1", alu_src1, m_s1);
            check("cmp_src2", alu_src2, m_s2);
            check("cmp_field", {30'd0, cur_field}, {30'd0, m_field});
            check("cmp_ready", {31'd0, operands_ready}, {31'd0, m_rdy});
            check("cmp_rpulse", {31'd0, ready_pulse}, {31'd0, m_rp});
            check("cmp_err", {31'd0, ctrl_trunc_err}, {31'd0, m_err});
            if (ready_pulse) rp_count++;
        end
    end

    task automatic enter(input logic [31:0] v);
        @(negedge clk);
        input_valid = 1'b1;
        input_value = v;
        @(negedge clk);
        input_valid = 1'b0;
    endtask

    task automatic press_next();
        @(negedge clk);
        btn_next_raw = 1'b1;
        repeat (D + 6) @(negedge clk);
        btn_next_raw = 1'b0;
        repeat (D + 6) @(negedge clk);
    endtask

    initial begin
        int lat;
        // Reset state
        #3;
        check("rst_control", {28'd0, alu_control}, 32'd0);
        check("rst_src1", alu_src1, 32'd0);
        check("rst_field", {30'd0, cur_field}, 32'd0);
        check("rst_ready", {31'd0, operands_ready}, 32'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        // Full entry sequence
        enter(32'h5);
        press_next();
        enter(32'h12345678);
        press_next();
        enter(32'h0000FFFF);
        rp_count = 0;
        press_next();
        check("t1_control", {28'd0, alu_control}, 32'h5);
        check("t1_src1", alu_src1, 32'h12345678);
        check("t1_src2", alu_src2, 32'h0000FFFF);
        check("t1_field", {30'd0, cur_field}, 32'd3);
        check("t1_ready", {31'd0, operands_ready}, 32'd1);
        check("t1_pulse_count", rp_count, 32'd1);
        check("t1_err", {31'd0, ctrl_trunc_err}, 32'd0);

        // Entry ignored in READY
        enter(32'hDEAD);
        check("t5_src1", alu_src1, 32'h12345678);
        check("t5_src2", alu_src2, 32'h0000FFFF);

        // Bouncy NEXT: advance on the 7th posedge after the stable high is driven
        @(negedge clk); btn_next_raw = 1'b1;
        @(negedge clk); btn_next_raw = 1'b0;
        @(negedge clk); btn_next_raw = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (cur_field != 2'd3) begin
                lat = i;
                break;
            end
        end
        check("t2_latency", lat, 32'd7);
        repeat (10) @(negedge clk);
        btn_next_raw = 1'b0;
        repeat (D + 6) @(negedge clk);
        check("t2_field", {30'd0, cur_field}, 32'd0);
        check("t2_ready", {31'd0, operands_ready}, 32'd0);
        check("t2_retain", alu_src2, 32'h0000FFFF);

        // Control truncation flag
        enter(32'h13);
        check("t3_control", {28'd0, alu_control}, 32'h3);
        check("t3_err_set", {31'd0, ctrl_trunc_err}, 32'd1);
        enter(32'h7);
        check("t3_control2", {28'd0, alu_control}, 32'h7);
        check("t3_err_clr", {31'd0, ctrl_trunc_err}, 32'd0);

        // Capture coincident with NEXT goes to the old field
        press_next();
        btn_next_raw = 1'b1;
        repeat (6) @(negedge clk);
        input_valid = 1'b1;
        input_value = 32'hAA;
        @(negedge clk);
        input_valid = 1'b0;
        check("t4_src1", alu_src1, 32'hAA);
        check("t4_field", {30'd0, cur_field}, 32'd2);
        repeat (D + 6) @(negedge clk);
        btn_next_raw = 1'b0;
        repeat (D + 6) @(negedge clk);

        // CLEAR wins over same-cycle capture
        btn_clear_raw = 1'b1;
        repeat (6) @(negedge clk);
        input_valid = 1'b1;
        input_value = 32'h55;
        @(negedge clk);
        input_valid = 1'b0;
        check("t6_src1", alu_src1, 32'd0);
        check("t6_src2", alu_src2, 32'd0);
        check("t6_control", {28'd0, alu_control}, 32'd0);
        check("t6_field", {30'd0, cur_field}, 32'd0);
        repeat (D + 6) @(negedge clk);
        btn_clear_raw = 1'b0;
        repeat (D + 6) @(negedge clk);

        // Async reset mid-debounce; a button held through release gives no advance
        enter(32'h9);
        check("t6_pre_rst", {28'd0, alu_control}, 32'h9);
        btn_next_raw = 1'b1;
        repeat (3) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("t6_async_control", {28'd0, alu_control}, 32'd0);
        check("t6_async_field", {30'd0, cur_field}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (D + 8) @(negedge clk);
        check("t6_held_no_adv", {30'd0, cur_field}, 32'd0);
        btn_next_raw = 1'b0;
        repeat (D + 6) @(negedge clk);
        press_next();
        check("t6_repress", {30'd0, cur_field}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
